// File: rtl/instruction_fetch_unit.sv
// Fetches num_inst consecutive imem words from base_addr and streams them to the decoder in order.
// Latency: start at T -> first imem read at T+1 -> inst_valid at T+3; sustains 1 word/cycle.
// Backpressure: inst_ready low fills the show-ahead FIFO; reads stop once FIFO + in-flight reach depth.

module ifu_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic                         head_vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    assign head_vld = (count != '0);
    // Gate the head so the data output reads as zero whenever the FIFO is empty.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
    assign pop      = head_vld && pop_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (push_vld && !pop)
                count <= count + CW'(1);
            else if (!push_vld && pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush)
            mem[wr_ptr] <= push_dat;
    end
endmodule

module instruction_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int COUNT_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [COUNT_W-1:0]    num_inst,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [COUNT_W-1:0]    num_q;
    logic [COUNT_W-1:0]    issued;
    logic [COUNT_W-1:0]    delivered;
    logic                  inflight;
    logic [CW-1:0]         fifo_cnt;
    logic [CW:0]           occupancy;
    logic                  pop;
    logic                  start_acc;

    // Occupancy counts the read still on its way back so the FIFO can never overflow.
    assign occupancy      = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
    assign imem_read_req  = (state == FETCH) && (issued < num_q) && (occupancy < DEPTH_L);
    assign imem_read_addr = addr_q;
    assign pop            = inst_valid && inst_ready;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign start_acc      = (state == IDLE) && start && !abort;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = (num_inst == '0) ? DONE : FETCH;
                FETCH:   if (imem_read_req && (issued + COUNT_W'(1) == num_q)) state_nxt = DRAIN;
                // Include this cycle's pop so done follows the last delivery immediately.
                DRAIN:   if (delivered + {{(COUNT_W-1){1'b0}}, pop} == num_q) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            num_q     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_read_req && !abort;
            if (start_acc) begin
                addr_q    <= base_addr;
                num_q     <= num_inst;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (imem_read_req) begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    issued <= issued + COUNT_W'(1);
                end
                if (pop)
                    delivered <= delivered + COUNT_W'(1);
            end
        end
    end

    ifu_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (abort),
        .push_vld (inflight),
        .push_dat (imem_read_data),
        .pop_rdy  (inst_ready),
        .head_vld (inst_valid),
        .head_dat (inst_data),
        .count    (fifo_cnt)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: stimulus queues expected read addresses and delivered words; a negedge
// monitor pops and compares them as the fetch unit presents reads and accepted words.
module tb_instruction_fetch_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [15:0] num_inst;
    logic        abort;
    logic        busy;
    logic        done;
    logic        imem_read_req;
    logic [10:0] imem_read_addr;
    logic [31:0] imem_read_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_ready;

    int vectors     = 0;
    int miscompares = 0;
    int req_cnt     = 0;
    int done_cnt    = 0;
    int dcnt0;

    logic [10:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_inst       (num_inst),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .imem_read_req  (imem_read_req),
        .imem_read_addr (imem_read_addr),
        .imem_read_data (imem_read_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a tagged copy of the address; non-requested cycles return garbage.
    initial imem_read_data = 32'h0;
    always @(posedge clk)
        imem_read_data <= imem_read_req ? (32'hC0DE_0000 | 32'(imem_read_addr)) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (imem_read_req) begin
                req_cnt++;
                if (exp_addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_addr: got unexpected read of %h expected none", imem_read_addr);
                end else begin
                    chk("rd_addr", 32'(imem_read_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_data_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL inst_data: got unexpected word %h expected none", inst_data);
                end else begin
                    chk("inst_data", inst_data, exp_data_q.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [10:0] base, input int n, input int ndata);
        for (int i = 0; i < n; i++) begin
            logic [10:0] a;
            a = base + 11'(i);
            exp_addr_q.push_back(a);
            if (i < ndata) exp_data_q.push_back(32'hC0DE_0000 | 32'(a));
        end
    endtask

    task automatic pulse_start(input logic [10:0] base, input logic [15:0] num);
        base_addr = base;
        num_inst  = num;
        start     = 1'b1;
        next_cyc();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            next_cyc();
            #2;
            if (done) seen = 1'b1;
        end
        chk1(name, seen, 1'b1);
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_addr_q"}, 32'(exp_addr_q.size()), 32'd0);
        chk({name, "_data_q"}, 32'(exp_data_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; inst_ready = 1'b0;
        base_addr = '0; num_inst = '0;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_req", imem_read_req, 1'b0);
        chk("rst_addr", 32'(imem_read_addr), 32'd0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_data", inst_data, 32'd0);
        next_cyc(); next_cyc();
        reset = 1'b1;
        next_cyc();

        // 1: base 0x010, 4 words, decoder always ready; exact cycle timing
        inst_ready = 1'b1;
        expect_fetch(11'h010, 4, 4);
        dcnt0 = done_cnt;
        pulse_start(11'h010, 16'd4);
        #2;
        chk1("t1_req_T1", imem_read_req, 1'b1);
        chk("t1_addr_T1", 32'(imem_read_addr), 32'h010);
        chk1("t1_busy_T1", busy, 1'b1);
        next_cyc(); #2;
        chk1("t1_valid_T2", inst_valid, 1'b0);
        next_cyc(); #2;
        chk1("t1_valid_T3", inst_valid, 1'b1);
        chk("t1_data_T3", inst_data, 32'hC0DE_0010);
        next_cyc(); next_cyc(); next_cyc(); #2;
        chk1("t1_valid_T6", inst_valid, 1'b1);
        chk("t1_data_T6", inst_data, 32'hC0DE_0013);
        next_cyc(); #2;
        chk1("t1_done_T7", done, 1'b1);
        chk1("t1_valid_T7", inst_valid, 1'b0);
        next_cyc(); #2;
        chk1("t1_done_T8", done, 1'b0);
        chk1("t1_busy_T8", busy, 1'b0);
        chk("t1_done_cnt", 32'(done_cnt - dcnt0), 32'd1);
        chk_empty("t1");

        // 2: 8 words with decoder stalled for 12 cycles; only 4 reads may issue
        next_cyc();
        inst_ready = 1'b0;
        req_cnt = 0;
        expect_fetch(11'h000, 8, 8);
        pulse_start(11'h000, 16'd8);
        repeat (11) next_cyc();
        #2;
        chk("t2_stall_reads", 32'(req_cnt), 32'd4);
        chk1("t2_valid_stall", inst_valid, 1'b1);
        chk("t2_head_stall", inst_data, 32'hC0DE_0000);
        inst_ready = 1'b1;
        wait_done("t2_done", 60);
        chk_empty("t2");

        // 3: address wrap past the top of imem
        next_cyc();
        expect_fetch(11'h7FE, 4, 4);
        pulse_start(11'h7FE, 16'd4);
        wait_done("t3_done", 40);
        chk_empty("t3");

        // 4: zero-length fetch goes straight to DONE
        next_cyc();
        pulse_start(11'h123, 16'd0);
        #2;
        chk1("t4_busy_T1", busy, 1'b1);
        chk1("t4_done_T1", done, 1'b1);
        chk1("t4_req_T1", imem_read_req, 1'b0);
        next_cyc(); #2;
        chk1("t4_busy_T2", busy, 1'b0);
        chk1("t4_done_T2", done, 1'b0);

        // 5: abort with a read in flight and a simultaneous start
        next_cyc();
        expect_fetch(11'h040, 5, 2);
        dcnt0 = done_cnt;
        pulse_start(11'h040, 16'd8);
        repeat (4) next_cyc();
        inst_ready = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        base_addr = 11'h099;
        num_inst = 16'd5;
        next_cyc();
        abort = 1'b0;
        start = 1'b0;
        #2;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_valid", inst_valid, 1'b0);
        chk1("t5_done", done, 1'b0);
        next_cyc(); #2;
        chk1("t5_valid_next", inst_valid, 1'b0);
        chk1("t5_busy_next", busy, 1'b0);
        chk("t5_no_done", 32'(done_cnt - dcnt0), 32'd0);
        chk_empty("t5_abort");
        inst_ready = 1'b1;
        expect_fetch(11'h020, 3, 3);
        next_cyc();
        pulse_start(11'h020, 16'd3);
        wait_done("t5_restart_done", 40);
        chk_empty("t5_restart");

        // 6: start ignored mid-FETCH, then asynchronous reset mid-FETCH
        next_cyc();
        expect_fetch(11'h100, 3, 1);
        pulse_start(11'h100, 16'd6);
        next_cyc();
        start = 1'b1;
        base_addr = 11'h300;
        num_inst = 16'd2;
        next_cyc();
        start = 1'b0;
        next_cyc();
        #2;
        reset = 1'b0;
        #1;
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_done", done, 1'b0);
        chk1("t6_req", imem_read_req, 1'b0);
        chk("t6_addr", 32'(imem_read_addr), 32'd0);
        chk1("t6_valid", inst_valid, 1'b0);
        chk("t6_data", inst_data, 32'd0);
        next_cyc(); next_cyc();
        reset = 1'b1;
        chk_empty("t6_reset");
        expect_fetch(11'h050, 2, 2);
        next_cyc();
        pulse_start(11'h050, 16'd2);
        wait_done("t6_recover_done", 40);
        chk_empty("t6_recover");

        next_cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
